// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared definitions for the ram_sdp_be storage block.
//               - RDW_OLD / RDW_NEW : read-during-write mode selectors
//               - clr_state_e       : clear FSM state encoding
//               - byte_merge()      : byte-lane merge of a write into a word
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // byte_merge works on a fixed maximum width. Callers size-cast their
    // words in and the result back out, so any DATA_W up to this width works.
    localparam int MERGE_MAX_W = 256;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_e;

    // Returns old_word with every byte lane whose enable is set replaced by
    // the corresponding lane of new_word.
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]   old_word,
        input logic [MERGE_MAX_W-1:0]   new_word,
        input logic [MERGE_MAX_W/8-1:0] lane_en
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_MAX_W/8; i++) begin
            if (lane_en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_clear_ctrl
// Description : Post-reset memory clear sequencer and array write mux.
//               While clearing, it writes zero to one location per cycle and
//               ignores user writes. Once ready, it passes user writes through,
//               except writes to addresses at or above DEPTH.
// Ports       : clk, rst_n          - clock / async active-low reset
//               we, waddr, din, be  - user write request
//               mem_we, mem_addr,
//               mem_din, mem_be     - write port into the storage array
//               init_done           - block accepts traffic
// Revision    : 1.0 - initial release
// ============================================================================
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   din,
    input  logic [DATA_W/8-1:0] be,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                init_done
);

    localparam logic [ADDR_W:0]   c_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST      = ADDR_W'(DEPTH - 1);
    // Without a clear pass the block comes out of reset already usable.
    localparam clr_state_e        c_RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
    localparam logic              c_RST_DONE  = (INIT_CLEAR != 0) ? 1'b0 : 1'b1;

    clr_state_e        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_init_done;
    logic              w_wr_in_range;

    assign w_wr_in_range = ({1'b0, waddr} < c_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_RST_STATE;
            r_cnt       <= '0;
            r_init_done <= c_RST_DONE;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    // The last location is written on this edge, so ready is
                    // flagged on the same edge.
                    if (r_cnt == c_LAST) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                default: ; // ST_READY holds until the next reset
            endcase
        end
    end

    always_comb begin
        mem_we   = 1'b1;
        mem_addr = r_cnt;
        mem_din  = '0;
        mem_be   = '1;
        if (r_state == ST_READY) begin
            mem_we   = we & w_wr_in_range;
            mem_addr = waddr;
            mem_din  = din;
            mem_be   = be;
        end
    end

    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: rtl/ram_sdp_be.sv
`default_nettype none
// ============================================================================
// Module      : ram_sdp_be
// Description : Simple dual-port synchronous RAM with per-byte write enables,
//               selectable read-during-write result, optional output register
//               and hardware clear after reset.
// Ports       : clk, rst_n          - clock / async active-low reset
//               we, waddr, din, be  - write port (be[i] gates din byte i)
//               re, raddr           - read port
//               dout, rvalid        - read data and its one-cycle strobe
//               init_done           - block accepts reads and writes
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   din,
    input  logic [DATA_W/8-1:0] be,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   dout,
    output logic                rvalid,
    output logic                init_done
);

    localparam int              c_BE_W  = DATA_W / 8;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > MERGE_MAX_W) begin : g_err_data_w
        $error("ram_sdp_be: DATA_W must be a non-zero multiple of 8 within the merge width");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_err_depth
        $error("ram_sdp_be: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_err_rdw
        $error("ram_sdp_be: RDW_MODE must be 0 or 1");
    end

    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_din;
    logic [c_BE_W-1:0]   w_mem_be;
    logic                w_init_done;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_rd_en;
    logic                w_rd_in_range;
    logic                w_rdw_hit;
    logic [DATA_W-1:0]   w_old_word;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   r_dout1;
    logic                r_rvalid1;

    ram_clear_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .din       (din),
        .be        (be),
        .mem_we    (w_mem_we),
        .mem_addr  (w_mem_addr),
        .mem_din   (w_mem_din),
        .mem_be    (w_mem_be),
        .init_done (w_init_done)
    );

    // Storage is deliberately not reset; the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < c_BE_W; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_addr][8*i +: 8] <= w_mem_din[8*i +: 8];
                end
            end
        end
    end

    assign w_rd_en       = re & w_init_done;
    assign w_rd_in_range = ({1'b0, raddr} < c_DEPTH);
    assign w_old_word    = w_rd_in_range ? r_mem[raddr] : '0;

    // A write on the same edge to the same address; w_mem_we is already
    // qualified for range, so a hit implies a valid location.
    assign w_rdw_hit = w_init_done && w_mem_we && (w_mem_addr == raddr);
    assign w_merged  = DATA_W'(byte_merge(MERGE_MAX_W'(w_old_word),
                                          MERGE_MAX_W'(din),
                                          (MERGE_MAX_W/8)'(be)));
    assign w_rd_word = (RDW_MODE == RDW_NEW && w_rdw_hit) ? w_merged : w_old_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout1   <= '0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid1 <= w_rd_en;
            if (w_rd_en) begin
                r_dout1 <= w_rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] r_dout2;
        logic              r_rvalid2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dout2   <= '0;
                r_rvalid2 <= 1'b0;
            end else begin
                r_rvalid2 <= r_rvalid1;
                // Only real read data advances, so dout holds between reads.
                if (r_rvalid1) begin
                    r_dout2 <= r_dout1;
                end
            end
        end

        assign dout   = r_dout2;
        assign rvalid = r_rvalid2;
    end else begin : g_no_out_reg
        assign dout   = r_dout1;
        assign rvalid = r_rvalid1;
    end

    assign init_done = w_init_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sdp_be
// Description : Directed self-checking bench. Two instances share stimulus:
//               u_a : DEPTH=16, RDW old data, no output register (latency 1)
//               u_b : DEPTH=12, RDW new data, output register    (latency 2)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sdp_be;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic [3:0]  waddr = 4'd0;
    logic [3:0]  raddr = 4'd0;
    logic [15:0] din   = 16'h0000;
    logic [1:0]  be    = 2'b00;

    logic [15:0] dout_a, dout_b;
    logic        rvalid_a, rvalid_b;
    logic        done_a, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_sdp_be #(
        .DATA_W(16), .ADDR_W(4), .DEPTH(16),
        .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .din(din), .be(be),
        .re(re), .raddr(raddr), .dout(dout_a), .rvalid(rvalid_a), .init_done(done_a)
    );

    ram_sdp_be #(
        .DATA_W(16), .ADDR_W(4), .DEPTH(12),
        .RDW_MODE(1), .OUT_REG(1), .INIT_CLEAR(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .din(din), .be(be),
        .re(re), .raddr(raddr), .dout(dout_b), .rvalid(rvalid_b), .init_done(done_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst done_a", done_a, 16'd0);
        check("rst done_b", done_b, 16'd0);
        check("rst rvalid_a", rvalid_a, 16'd0);
        check("rst rvalid_b", rvalid_b, 16'd0);
        check("rst dout_a", dout_a, 16'h0000);
        check("rst dout_b", dout_b, 16'h0000);

        // ---------------- clear, with traffic at cycle 5 ----------------
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) begin
                we = 1'b1; waddr = 4'd7; din = 16'h5555; be = 2'b11;
                re = 1'b1; raddr = 4'd7;
            end
            tick();
            we = 1'b0; re = 1'b0;
            check($sformatf("clr1 done_a k%0d", k), done_a, 16'd0);
            check($sformatf("clr1 done_b k%0d", k), done_b, 16'd0);
            check($sformatf("clr1 rvalid_a k%0d", k), rvalid_a, 16'd0);
            check($sformatf("clr1 rvalid_b k%0d", k), rvalid_b, 16'd0);
        end

        // Reset pulse mid-clear restarts the sequence from location 0.
        rst_n = 1'b0;
        #2;
        check("midrst done_a", done_a, 16'd0);
        check("midrst done_b", done_b, 16'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("clr2 done_a k%0d", k), done_a, (k >= 16) ? 16'd1 : 16'd0);
            check($sformatf("clr2 done_b k%0d", k), done_b, (k >= 12) ? 16'd1 : 16'd0);
        end

        // ---------------- read sweep of cleared memory ----------------
        for (int i = 0; i < 16; i++) begin
            re = 1'b1; raddr = 4'(i);
            tick();
            check($sformatf("sweep rvalid_a %0d", i), rvalid_a, 16'd1);
            check($sformatf("sweep dout_a %0d", i), dout_a, 16'h0000);
            check($sformatf("sweep rvalid_b %0d", i), rvalid_b, (i >= 1) ? 16'd1 : 16'd0);
            check($sformatf("sweep dout_b %0d", i), dout_b, 16'h0000);
        end
        re = 1'b0;
        tick();
        check("sweep end rvalid_a", rvalid_a, 16'd0);
        check("sweep end rvalid_b", rvalid_b, 16'd1);
        tick();
        check("sweep idle rvalid_b", rvalid_b, 16'd0);

        // ---------------- byte-enabled writes ----------------
        we = 1'b1; waddr = 4'd3; din = 16'hA5C3; be = 2'b11;
        tick();
        din = 16'h1200; be = 2'b10;
        tick();
        we = 1'b0; re = 1'b1; raddr = 4'd3;
        tick();
        re = 1'b0;
        check("be rd dout_a", dout_a, 16'h12C3);
        check("be rd rvalid_a", rvalid_a, 16'd1);
        check("be rd early rvalid_b", rvalid_b, 16'd0);
        tick();
        check("be rd dout_b", dout_b, 16'h12C3);
        check("be rd rvalid_b", rvalid_b, 16'd1);
        check("be rd hold dout_a", dout_a, 16'h12C3);
        check("be rd idle rvalid_a", rvalid_a, 16'd0);

        // we=1 with be=0 must not change the word.
        we = 1'b1; waddr = 4'd3; din = 16'hFFFF; be = 2'b00;
        tick();
        we = 1'b0; re = 1'b1; raddr = 4'd3;
        tick();
        re = 1'b0;
        check("be0 dout_a", dout_a, 16'h12C3);
        tick();
        check("be0 dout_b", dout_b, 16'h12C3);

        // ---------------- read-during-write ----------------
        we = 1'b1; waddr = 4'd5; din = 16'h1111; be = 2'b11;
        tick();
        din = 16'hBEEF; be = 2'b01; re = 1'b1; raddr = 4'd5;
        tick();
        we = 1'b0;
        check("rdw old dout_a", dout_a, 16'h1111);
        check("rdw old rvalid_a", rvalid_a, 16'd1);
        tick();
        re = 1'b0;
        check("rdw next dout_a", dout_a, 16'h11EF);
        check("rdw new dout_b", dout_b, 16'h11EF);
        check("rdw new rvalid_b", rvalid_b, 16'd1);
        tick();
        check("rdw next dout_b", dout_b, 16'h11EF);
        check("rdw next rvalid_b", rvalid_b, 16'd1);
        check("rdw idle rvalid_a", rvalid_a, 16'd0);

        // ---------------- out-of-range on the DEPTH=12 instance ----------------
        we = 1'b1; waddr = 4'd14; din = 16'hFFFF; be = 2'b11;
        tick();
        we = 1'b0; re = 1'b1; raddr = 4'd14;
        tick();
        check("oor a14 dout_a", dout_a, 16'hFFFF);
        check("oor a14 rvalid_a", rvalid_a, 16'd1);
        raddr = 4'd2;
        tick();
        check("oor a2 dout_a", dout_a, 16'h0000);
        check("oor b14 dout_b", dout_b, 16'h0000);
        check("oor b14 rvalid_b", rvalid_b, 16'd1);
        raddr = 4'd11;
        tick();
        re = 1'b0;
        check("oor a11 dout_a", dout_a, 16'h0000);
        check("oor b2 dout_b", dout_b, 16'h0000);
        tick();
        check("oor idle rvalid_a", rvalid_a, 16'd0);
        check("oor b11 dout_b", dout_b, 16'h0000);
        check("oor b11 rvalid_b", rvalid_b, 16'd1);

        // ---------------- back-to-back reads ----------------
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; waddr = 4'(i); din = 16'h0010 + 16'(i); be = 2'b11;
            tick();
        end
        we = 1'b0;
        for (int j = 0; j < 4; j++) begin
            re = 1'b1; raddr = 4'(j);
            tick();
            check($sformatf("b2b dout_a %0d", j), dout_a, 16'h0010 + 16'(j));
            check($sformatf("b2b rvalid_a %0d", j), rvalid_a, 16'd1);
            check($sformatf("b2b rvalid_b %0d", j), rvalid_b, (j >= 1) ? 16'd1 : 16'd0);
            if (j >= 1) begin
                check($sformatf("b2b dout_b %0d", j), dout_b, 16'h0010 + 16'(j - 1));
            end
        end
        re = 1'b0;
        tick();
        check("b2b tail rvalid_a", rvalid_a, 16'd0);
        check("b2b tail dout_b", dout_b, 16'h0013);
        check("b2b tail rvalid_b", rvalid_b, 16'd1);
        tick();
        check("b2b idle rvalid_b", rvalid_b, 16'd0);
        check("b2b idle dout_b", dout_b, 16'h0013);

        // ---------------- reset flushes in-flight read ----------------
        re = 1'b1; raddr = 4'd1;
        tick();
        re = 1'b0;
        check("flush pre dout_a", dout_a, 16'h0011);
        rst_n = 1'b0;
        #2;
        check("flush dout_a", dout_a, 16'h0000);
        check("flush rvalid_a", rvalid_a, 16'd0);
        check("flush dout_b", dout_b, 16'h0000);
        check("flush rvalid_b", rvalid_b, 16'd0);
        check("flush done_a", done_a, 16'd0);
        check("flush done_b", done_b, 16'd0);
        tick();
        check("flush held rvalid_b", rvalid_b, 16'd0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
